// File: rtl/result_checker_pkg.sv
// result_checker_pkg: state encoding and saturating-step constant shared by the checker and its counter
package result_checker_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;
   localparam logic SAT_INC = 1'b1;
endpackage

// File: rtl/result_checker_sat_counter.sv
// sat_counter: error counter that clears on clr, steps on inc and sticks at all-ones
module sat_counter
   import result_checker_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);
   (* preserve *) logic [W-1:0] r_count;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_count <= '0;
      else if (clr) r_count <= '0;
      else if (inc && r_count != '1) r_count <= r_count + W'(SAT_INC);
   assign count = r_count;
endmodule

// File: rtl/result_checker.sv
// result_checker: compares dut_data against ref_data on every other clock after a discard window,
// counting mismatches and capturing the first one
module result_checker
   import result_checker_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int SAMPLE_PHASE = 1,
   parameter int DISCARD      = 2,
   parameter int CNT_W        = 32,
   parameter int ERR_W        = 16
) (
   input  logic             pll_clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [WIDTH-1:0] dut_data,
   input  logic [WIDTH-1:0] ref_data,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count,
   output logic             err_sticky,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_dut,
   output logic [WIDTH-1:0] first_err_ref
);
   (* preserve *) logic             r_phase;
   (* preserve *) state_t           r_state;
   (* preserve *) logic             r_busy;
   (* preserve *) logic             r_done;
   (* preserve *) logic             r_sticky;
   (* preserve *) logic [CNT_W-1:0] r_fidx;
   (* preserve *) logic [WIDTH-1:0] r_fdut;
   (* preserve *) logic [WIDTH-1:0] r_fref;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_disc;
   logic [CNT_W-1:0] r_idx;
   logic             w_slot;
   logic             w_go;
   logic             w_mis;
   assign w_slot = r_phase == 1'(SAMPLE_PHASE);
   assign w_go   = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_mis  = r_state == S_RUN && w_slot && dut_data != ref_data;
   always_ff @(posedge pll_clock or posedge reset)
      if (reset) begin
         r_phase  <= 1'b0;
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sticky <= 1'b0;
         r_fidx   <= '0;
         r_fdut   <= '0;
         r_fref   <= '0;
         r_num    <= '0;
         r_disc   <= '0;
         r_idx    <= '0;
      end else begin
         r_phase <= ~r_phase;
         if (w_go) begin
            r_num    <= num_samples;
            r_disc   <= CNT_W'(DISCARD);
            r_idx    <= '0;
            r_sticky <= 1'b0;
            r_fidx   <= '0;
            r_fdut   <= '0;
            r_fref   <= '0;
            r_state  <= num_samples != '0 ? S_ARM : S_DONE;
            r_busy   <= num_samples != '0;
            r_done   <= num_samples == '0;
         end else if (r_state == S_ARM) begin
            if (r_disc == '0) r_state <= S_RUN;
            else if (w_slot) begin
               r_disc <= r_disc - CNT_W'(1);
               if (r_disc == CNT_W'(1)) r_state <= S_RUN;
            end
         end else if (r_state == S_RUN && w_slot) begin
            r_idx <= r_idx + CNT_W'(1);
            if (w_mis && !r_sticky) begin
               r_sticky <= 1'b1;
               r_fidx   <= r_idx;
               r_fdut   <= dut_data;
               r_fref   <= ref_data;
            end
            // the final compare happens on this same edge, so leave RUN only after it
            if (r_idx == r_num - CNT_W'(1)) begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end
      end
   sat_counter #(.W(ERR_W)) u_err (
      .clk  (pll_clock),
      .rst  (reset),
      .inc  (w_mis),
      .clr  (w_go),
      .count(err_count)
   );
   assign busy          = r_busy;
   assign done          = r_done;
   assign err_sticky    = r_sticky;
   assign first_err_idx = r_fidx;
   assign first_err_dut = r_fdut;
   assign first_err_ref = r_fref;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: directed vector table plus hand sequences for zero-length runs,
// start-while-busy, restart and mid-run reset; a second instance with ERR_W=4 checks saturation
module tb_result_checker;
   import result_checker_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] num_samples = '0;
   logic [31:0] dut_data = '0;
   logic [31:0] ref_data = '0;
   logic        busy, done, sticky;
   logic [15:0] err;
   logic [31:0] fidx, fdut, fref;
   logic        s_busy, s_done, s_sticky;
   logic [3:0]  s_err;
   logic [31:0] s_fidx, s_fdut, s_fref;
   logic        tb_phase;
   int          n_pass = 0;
   int          n_total = 0;

   typedef struct {
      int          n;
      int          ma;
      int          mb;
      bit          all;
      logic [15:0] err;
      logic [3:0]  sat;
      logic        st;
      logic [31:0] idx;
      logic [31:0] fd;
      logic [31:0] fr;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset)
      if (reset) tb_phase <= 1'b0;
      else tb_phase <= ~tb_phase;

   result_checker dut (
      .pll_clock(clk), .reset(reset), .start(start), .num_samples(num_samples),
      .dut_data(dut_data), .ref_data(ref_data), .busy(busy), .done(done),
      .err_count(err), .err_sticky(sticky), .first_err_idx(fidx),
      .first_err_dut(fdut), .first_err_ref(fref)
   );

   result_checker #(.ERR_W(4)) u_sat (
      .pll_clock(clk), .reset(reset), .start(start), .num_samples(num_samples),
      .dut_data(dut_data), .ref_data(ref_data), .busy(s_busy), .done(s_done),
      .err_count(s_err), .err_sticky(s_sticky), .first_err_idx(s_fidx),
      .first_err_dut(s_fdut), .first_err_ref(s_fref)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic set_data(input vec_t v, input int k);
      if (v.all || k == v.ma || k == v.mb) begin
         dut_data = 32'hFC + k;
         ref_data = 32'hFB + k;
      end else begin
         dut_data = 32'h1000 + k;
         ref_data = 32'h1000 + k;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_sat_err"}, s_err, 0);
      chk({tag, "_sticky"}, sticky, 0);
      chk({tag, "_fidx"}, fidx, 0);
      chk({tag, "_fdut"}, fdut, 0);
      chk({tag, "_fref"}, fref, 0);
   endtask

   // start on a non-slot edge so sample k lands on edge s+5+2k (two discard slots first)
   task automatic run_vec(input vec_t v, input bit poke, input string tag);
      if (tb_phase) tick();
      num_samples = v.n;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_start_busy"}, busy, v.n != 0);
      chk({tag, "_start_done"}, done, v.n == 0);
      chk({tag, "_start_err"}, err, 0);
      chk({tag, "_start_sticky"}, sticky, 0);
      chk({tag, "_start_fidx"}, fidx, 0);
      chk({tag, "_start_fdut"}, fdut, 0);
      if (v.n == 0) return;
      repeat (4) tick();
      for (int k = 0; k < v.n; k++) begin
         set_data(v, k);
         if (poke && k == 1) begin
            start = 1'b1;
            num_samples = 0;
         end
         if (k == v.n - 1) begin
            chk({tag, "_pre_done"}, done, 0);
            chk({tag, "_pre_busy"}, busy, 1);
         end
         tick();
         if (poke && k == 1) begin
            start = 1'b0;
            chk({tag, "_poke_busy"}, busy, 1);
            chk({tag, "_poke_done"}, done, 0);
         end
         if (k != v.n - 1) tick();
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, v.err);
      chk({tag, "_sat_err"}, s_err, v.sat);
      chk({tag, "_sticky"}, sticky, v.st);
      chk({tag, "_fidx"}, fidx, v.idx);
      chk({tag, "_fdut"}, fdut, v.fd);
      chk({tag, "_fref"}, fref, v.fr);
      chk({tag, "_sat_done"}, s_done, 1);
      chk({tag, "_sat_fidx"}, s_fidx, v.idx);
      chk({tag, "_sat_fdut"}, s_fdut, v.fd);
      chk({tag, "_sat_fref"}, s_fref, v.fr);
      chk({tag, "_sat_sticky"}, s_sticky, v.st);
      chk({tag, "_sat_busy"}, s_busy, 0);
   endtask

   initial begin
      vecs[0] = '{8, -1, -1, 1'b0, 16'd0, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0};
      vecs[1] = '{8, 3, -1, 1'b0, 16'd1, 4'd1, 1'b1, 32'd3, 32'hFF, 32'hFE};
      vecs[2] = '{8, 2, 6, 1'b0, 16'd2, 4'd2, 1'b1, 32'd2, 32'hFE, 32'hFD};
      vecs[3] = '{20, -1, -1, 1'b1, 16'd20, 4'd15, 1'b1, 32'd0, 32'hFC, 32'hFB};
      vecs[4] = '{1, 0, -1, 1'b0, 16'd1, 4'd1, 1'b1, 32'd0, 32'hFC, 32'hFB};
      vecs[5] = '{5, 4, -1, 1'b0, 16'd1, 4'd1, 1'b1, 32'd4, 32'h100, 32'hFF};
      #23;
      check_all_zero("reset");
      chk("reset_phase", dut.r_phase, 0);
      chk("reset_state", dut.r_state, S_IDLE);
      #2 reset = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
      begin
         vec_t z;
         z = '{0, -1, -1, 1'b0, 16'd0, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0};
         run_vec(z, 1'b0, "zero");
         for (int i = 0; i < 4; i++) begin
            tick();
            chk("zero_idle_busy", busy, 0);
            chk("zero_idle_done", done, 1);
         end
      end
      run_vec(vecs[1], 1'b1, "poke");
      begin
         vec_t m;
         m = '{8, 1, -1, 1'b0, 16'd0, 4'd0, 1'b0, 32'd0, 32'h0, 32'h0};
         if (tb_phase) tick();
         num_samples = 8;
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (4) tick();
         for (int k = 0; k < 4; k++) begin
            set_data(m, k);
            tick();
            tick();
         end
         chk("midrst_pre_err", err, 1);
         chk("midrst_pre_busy", busy, 1);
         chk("midrst_pre_fidx", fidx, 1);
         #2 reset = 1'b1;
         #1;
         check_all_zero("midrst");
         chk("midrst_state", dut.r_state, S_IDLE);
         chk("midrst_phase", dut.r_phase, 0);
         #1 reset = 1'b0;
         tick();
      end
      run_vec(vecs[2], 1'b0, "post_rst");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter WIDTH, default 32: width of DUT and reference data.
REQ-002 Parameter SAMPLE_PHASE, default 1: value of the internal phase bit on which a sample is taken.
REQ-003 Parameter DISCARD, default 2: number of sample slots skipped after start, to flush the upstream delay stages.
REQ-004 Parameter CNT_W, default 32: width of the sample-count and index fields.
REQ-005 Parameter ERR_W, default 16: width of the error counter.
REQ-006 pll_clock  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to begin a check run.
REQ-009 num_samples  input  CNT_W  number of compared samples in a run; latched on accepted start.
REQ-010 dut_data  input  WIDTH  registered output of the upstream data_delay stage.
REQ-011 ref_data  input  WIDTH  golden value aligned to dut_data.
REQ-012 busy  output  1  high in ARM and RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 err_count  output  ERR_W  number of mismatching samples, saturating.
REQ-015 err_sticky  output  1  set on the first mismatch of a run.
REQ-016 first_err_idx  output  CNT_W  sample index (0-based, post-discard) of the first mismatch.
REQ-017 first_err_dut  output  WIDTH  dut_data captured at the first mismatch.
REQ-018 first_err_ref  output  WIDTH  ref_data captured at the first mismatch.

Function
REQ-019 Phase: the 1-bit phase register shall reset to 0 and toggle on every clock; slot = (phase == SAMPLE_PHASE).
REQ-020 States: IDLE, ARM, RUN, DONE; reset state is IDLE.
REQ-021 IDLE: start=1 shall latch num_samples, clear all result outputs, and go to ARM if num_samples != 0, otherwise to DONE.
REQ-022 ARM: a discard counter shall decrement on each slot; after DISCARD slots the block shall go to RUN (DISCARD=0 means directly to RUN on the next clock).
REQ-023 RUN: on each slot the block shall compare dut_data and ref_data (full-width inequality) and increment the sample index.
REQ-024 Mismatch: err_count shall increment by 1, holding at all-ones with no wrap.
REQ-025 First mismatch only: err_sticky shall be set to 1, and first_err_idx, first_err_dut and first_err_ref shall be captured in the same clock.
REQ-026 Later mismatches shall leave the first_err_* fields unchanged.
REQ-027 RUN shall go to DONE on the clock that processes slot index num_samples-1; that final compare shall be included in the results.
REQ-028 DONE: outputs shall hold; start=1 shall begin a new run exactly as from IDLE (clear, latch, ARM or DONE).
REQ-029 start shall be ignored while busy=1.
REQ-030 Non-slot cycles shall never update the counters or the captured fields.
REQ-031 Latency: a result update shall be visible on the outputs one clock after the sampling edge.

Reset
REQ-032 Asserting reset shall asynchronously force: state IDLE, phase 0, busy 0, done 0, err_count 0, err_sticky 0, all first_err_* fields 0, and all internal counters 0.
REQ-033 Reset asserted during a run shall abort it with no partial results retained.
REQ-034 After reset is released, the first clock shall see phase=0.

Structure
REQ-035 A shared package shall hold the state enumeration and the saturating-increment width constant.
REQ-036 One sub-module, sat_counter (parameterised width, with inc and clr inputs), shall implement err_count.
REQ-037 All outputs shall be driven directly by registers.
REQ-038 The phase, state and result registers shall carry preserve attributes so that synthesis neither merges nor retimes them.

Verification
REQ-039 Matching stream: num_samples=8, DISCARD=2, dut=ref=incrementing values -> done after 10 slots, err_count=0, err_sticky=0.
REQ-040 Single mismatch: sample 3 has dut=0x0000_00FF and ref=0x0000_00FE -> err_count=1, first_err_idx=3, first_err_dut=0xFF, first_err_ref=0xFE.
REQ-041 Saturation: ERR_W=4, all 20 samples mismatch -> err_count=15, first_err_idx=0.
REQ-042 Zero samples: start with num_samples=0 -> done=1 on the next clock, busy never asserted.
REQ-043 Start while busy, and restart: start pulsed in RUN -> ignored; start in DONE -> outputs cleared and busy=1 on the next clock.
REQ-044 Mid-run reset: reset at slot 4 of 8 -> all outputs 0 immediately, state IDLE, phase 0.
